// File: rtl/fc_layer_seq_if.sv
// Host-write, activation-input and neuron-output signals of fc_layer_seq, bundled for port connection.
// The slave modport is the layer itself; the master modport is the host/upstream/downstream side.
interface fc_layer_seq_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 15
);
    logic [DATA_WIDTH-1:0]   riscv_data;
    logic [ADDRESS_BITS-1:0] riscv_address;
    logic                    wm_enable_write;
    logic                    bm_enable_write;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    data_in_valid;
    logic                    data_in_ready;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_out_valid;
    logic                    busy;
    logic                    done;

    modport slave (
        input  riscv_data, riscv_address, wm_enable_write, bm_enable_write,
        input  data_in, data_in_valid,
        output data_in_ready, data_out, data_out_valid, busy, done
    );

    modport master (
        output riscv_data, riscv_address, wm_enable_write, bm_enable_write,
        output data_in, data_in_valid,
        input  data_in_ready, data_out, data_out_valid, busy, done
    );
endinterface

// File: rtl/fc_layer_seq.sv
// LeNet5 F6 fully-connected stage: buffers one C5 frame, then evaluates each neuron with one MAC.
// Define FC_RELU_EN to clamp negative neuron results to zero at the output stage.
module fc_layer_seq #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAC_BITS    = 16,
    parameter int ADDRESS_BITS = 15,
    parameter int NUM_INPUTS   = 120,
    parameter int NUM_OUTPUTS  = 84
) (
    input  logic          clk,
    input  logic          reset,
    fc_layer_seq_if.slave io_bus
);
    localparam int WM_DEPTH = NUM_INPUTS * NUM_OUTPUTS;
    localparam int WA = (WM_DEPTH > 1) ? $clog2(WM_DEPTH) : 1;
    localparam int BA = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int XA = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [WA:0] WM_LIMIT = (WA+1)'(WM_DEPTH);
    localparam logic [BA:0] BM_LIMIT = (BA+1)'(NUM_OUTPUTS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [DATA_WIDTH-1:0] r_wmem [WM_DEPTH];
    logic [DATA_WIDTH-1:0] r_bmem [NUM_OUTPUTS];
    logic [DATA_WIDTH-1:0] r_xbuf [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] r_w_rd, r_x_rd, r_b_rd;

    logic [XA-1:0]         r_in_cnt, r_idx;
    logic [BA-1:0]         r_j;
    logic [WA-1:0]         r_wptr;
    logic [DATA_WIDTH-1:0] r_acc, r_data_out;
    logic                  r_prod_vld, r_out_valid, r_done;

    logic                  w_busy, w_ready, w_in_we, w_wm_we, w_bm_we;
    logic                  w_last_in, w_last_idx, w_last_j;
    logic [WA-1:0]         w_wm_addr;
    logic [BA-1:0]         w_bm_addr;
    logic signed [PW-1:0]  w_prod_full;
    logic [DATA_WIDTH-1:0] w_prod_q, w_sum, w_result;

    assign w_last_in  = (r_in_cnt == XA'(NUM_INPUTS - 1));
    assign w_last_idx = (r_idx == XA'(NUM_INPUTS - 1));
    assign w_last_j   = (r_j == BA'(NUM_OUTPUTS - 1));
    assign w_in_we    = w_ready && io_bus.data_in_valid;

    // Host writes only land while the datapath is quiescent; out-of-range low-bit addresses are dropped.
    assign w_wm_addr = io_bus.riscv_address[WA-1:0];
    assign w_bm_addr = io_bus.riscv_address[BA-1:0];
    assign w_wm_we   = io_bus.wm_enable_write && !w_busy && ({1'b0, w_wm_addr} < WM_LIMIT);
    assign w_bm_we   = io_bus.bm_enable_write && !w_busy && ({1'b0, w_bm_addr} < BM_LIMIT);

    assign w_prod_full = PW'($signed(r_w_rd)) * PW'($signed(r_x_rd));
    assign w_prod_q    = DATA_WIDTH'(w_prod_full >>> FRAC_BITS);
    assign w_sum       = r_acc + r_b_rd;
`ifdef FC_RELU_EN
    assign w_result    = w_sum[DATA_WIDTH-1] ? '0 : w_sum;
`else
    assign w_result    = w_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (io_bus.data_in_valid) w_state_next = w_last_in ? S_MAC : S_LOAD;
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (io_bus.data_in_valid && w_last_in) w_state_next = S_MAC;
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (w_last_idx) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy       = 1'b1;
                w_state_next = S_OUT;
            end
            S_OUT: begin
                w_busy       = 1'b1;
                w_state_next = w_last_j ? S_DONE : S_MAC;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_cnt    <= '0;
            r_idx       <= '0;
            r_j         <= '0;
            r_wptr      <= '0;
            r_acc       <= '0;
            r_data_out  <= '0;
            r_prod_vld  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= (r_state == S_DONE);
            r_prod_vld  <= (r_state == S_MAC);
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_idx  <= '0;
                    r_j    <= '0;
                    r_wptr <= '0;
                    if (w_in_we) r_in_cnt <= w_last_in ? '0 : r_in_cnt + XA'(1);
                end
                S_MAC: begin
                    // The weight pointer runs straight through all rows, so it never needs j*NUM_INPUTS.
                    r_idx  <= w_last_idx ? '0 : r_idx + XA'(1);
                    r_wptr <= r_wptr + WA'(1);
                    if (r_idx == '0)    r_acc <= '0;
                    else if (r_prod_vld) r_acc <= r_acc + w_prod_q;
                end
                S_DRAIN: r_acc <= r_acc + w_prod_q;
                S_OUT: begin
                    r_data_out  <= w_result;
                    r_out_valid <= 1'b1;
                    r_j         <= w_last_j ? '0 : r_j + BA'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wm_we) r_wmem[w_wm_addr] <= io_bus.riscv_data;
        if (w_bm_we) r_bmem[w_bm_addr] <= io_bus.riscv_data;
        if (w_in_we) r_xbuf[r_in_cnt]  <= io_bus.data_in;
        if (r_state == S_MAC) begin
            r_w_rd <= r_wmem[r_wptr];
            r_x_rd <= r_xbuf[r_idx];
        end
        r_b_rd <= r_bmem[r_j];
    end

    assign io_bus.data_in_ready  = w_ready;
    assign io_bus.busy           = w_busy;
    assign io_bus.data_out       = r_data_out;
    assign io_bus.data_out_valid = r_out_valid;
    assign io_bus.done           = r_done;
endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: random frames checked against a plain-arithmetic neuron model,
// including output timing, host-write blocking, mid-frame reset and modular wrap.
module tb_fc_layer_seq;
    localparam int DW  = 32;
    localparam int FB  = 16;
    localparam int AB  = 15;
    localparam int NI  = 4;
    localparam int NO  = 3;
    localparam int WD  = NI * NO;
    localparam int WAT = $clog2(WD);
    localparam int BAT = $clog2(NO);
    localparam int PERIOD = NI + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    fc_layer_seq_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

    fc_layer_seq #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .ADDRESS_BITS(AB),
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int at; } exp_t;
    exp_t sb_q[$];
    int   done_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_w [WD];
    logic [31:0] m_b [NO];
    logic [31:0] m_x [NI];

    // Reference neuron: y = sum(trunc((w*x) >>> FB)) + b, all wrapping at 32 bits.
    function automatic logic [31:0] ref_neuron(input int j);
        logic [31:0] acc;
        logic [31:0] y;
        longint      p;
        acc = 32'd0;
        for (int i = 0; i < NI; i++) begin
            p   = longint'($signed(m_w[j*NI+i])) * longint'($signed(m_x[i]));
            p   = p >>> FB;
            acc = acc + p[31:0];
        end
        y = acc + m_b[j];
`ifdef FC_RELU_EN
        if (y[31]) y = 32'd0;
`endif
        return y;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (bus.data_out_valid === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: data_out=%h at cycle %0d, none required", bus.data_out, cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus.data_out !== e.data || cyc != e.at) begin
                    n_err++;
                    $display("FAIL neuron_out: got %h @cycle %0d, required %h @cycle %0d",
                             bus.data_out, cyc, e.data, e.at);
                end else
                    $display("neuron_out ok: %h @cycle %0d", bus.data_out, cyc);
            end
        end
        if (bus.done === 1'b1) begin
            n_vec++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done at cycle %0d, none required", cyc);
            end else begin
                d = done_q.pop_front();
                if (cyc != d) begin
                    n_err++;
                    $display("FAIL done_pulse: got cycle %0d, required cycle %0d", cyc, d);
                end else
                    $display("done ok @cycle %0d", cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else
            $display("%s ok: %h", name, act);
    endtask

    task automatic host_w(input int idx, input logic [31:0] val, input bit apply);
        @(negedge clk);
        bus.riscv_address   = AB'(($urandom() << WAT) | idx);
        bus.riscv_data      = val;
        bus.wm_enable_write = 1'b1;
        @(posedge clk);
        #1 bus.wm_enable_write = 1'b0;
        if (apply) m_w[idx] = val;
    endtask

    task automatic host_b(input int idx, input logic [31:0] val, input bit apply);
        @(negedge clk);
        bus.riscv_address   = AB'(($urandom() << BAT) | idx);
        bus.riscv_data      = val;
        bus.bm_enable_write = 1'b1;
        @(posedge clk);
        #1 bus.bm_enable_write = 1'b0;
        if (apply) m_b[idx] = val;
    endtask

    task automatic load_random_params();
        for (int k = 0; k < WD; k++) host_w(k, $urandom(), 1'b1);
        for (int k = 0; k < NO; k++) host_b(k, $urandom(), 1'b1);
    endtask

    // Streams m_x; e returns the edge count at which the last activation is stored (MAC entry).
    task automatic send_frame(input int gap, output int e);
        for (int i = 0; i < NI; i++) begin
            repeat (gap) @(negedge clk);
            @(negedge clk);
            bus.data_in       = m_x[i];
            bus.data_in_valid = 1'b1;
            e = cyc + 1;
            @(posedge clk);
            #1 bus.data_in_valid = 1'b0;
        end
    endtask

    task automatic push_model(input int e, input int nneur, input bit with_done);
        exp_t x;
        for (int j = 0; j < nneur; j++) begin
            x.data = ref_neuron(j);
            x.at   = e + PERIOD * (j + 1);
            sb_q.push_back(x);
        end
        if (with_done) done_q.push_back(e + PERIOD * NO + 1);
    endtask

    task automatic check_ready_drop();
        @(negedge clk);
        check("ready_drop", 32'(bus.data_in_ready), 32'd0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && (sb_q.size() != 0 || done_q.size() != 0); k++) @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d outputs and %0d done pulses still pending, required 0",
                     sb_q.size(), done_q.size());
            sb_q.delete();
            done_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int gap);
        int e;
        send_frame(gap, e);
        push_model(e, NO, 1'b1);
        check_ready_drop();
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e;
        exp_t x;
        bus.riscv_data      = '0;
        bus.riscv_address   = '0;
        bus.wm_enable_write = 1'b0;
        bus.bm_enable_write = 1'b0;
        bus.data_in         = '0;
        bus.data_in_valid   = 1'b0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out",  bus.data_out, 32'd0);
        check("rst_valid",     32'(bus.data_out_valid), 32'd0);
        check("rst_done",      32'(bus.done), 32'd0);
        check("rst_busy",      32'(bus.busy), 32'd0);
        check("rst_ready",     32'(bus.data_in_ready), 32'd1);
        reset = 1'b0;

        // Identity rows for neurons 0/1, zero row for neuron 2; results fixed by hand.
        for (int k = 0; k < WD; k++) host_w(k, ((k / NI) < 2 && (k % NI) == (k / NI)) ? 32'h10000 : 32'h0, 1'b1);
        for (int k = 0; k < NO; k++) host_b(k, 32'h0, 1'b1);
        for (int i = 0; i < NI; i++) m_x[i] = 32'h10000 * (i + 1);
        send_frame(0, e);
        x.data = 32'h10000; x.at = e + 6;  sb_q.push_back(x);
        x.data = 32'h20000; x.at = e + 12; sb_q.push_back(x);
        x.data = 32'h0;     x.at = e + 18; sb_q.push_back(x);
        done_q.push_back(e + 19);
        check_ready_drop();
        wait_idle();

        // Bias and sign: 4 * (0.5 * -1.0) + 0.25 = -1.75.
        for (int k = 0; k < WD; k++) host_w(k, 32'h8000, 1'b1);
        host_b(0, 32'h4000, 1'b1);
        host_b(1, 32'h0, 1'b1);
        host_b(2, 32'h0, 1'b1);
        for (int i = 0; i < NI; i++) m_x[i] = 32'hFFFF0000;
        send_frame(0, e);
`ifdef FC_RELU_EN
        x.data = 32'h0;
`else
        x.data = 32'hFFFE4000;
`endif
        x.at = e + 6;
        sb_q.push_back(x);
        for (int j = 1; j < NO; j++) begin
            x.data = ref_neuron(j);
            x.at   = e + PERIOD * (j + 1);
            sb_q.push_back(x);
        end
        done_q.push_back(e + PERIOD * NO + 1);
        wait_idle();

        // Same random frame back-to-back and with valid every third cycle.
        load_random_params();
        for (int i = 0; i < NI; i++) m_x[i] = $urandom();
        run_frame(0);
        run_frame(2);

        // Host writes while busy must be ignored in this and the next frame.
        load_random_params();
        for (int i = 0; i < NI; i++) m_x[i] = $urandom();
        send_frame(0, e);
        push_model(e, NO, 1'b1);
        while (cyc < e + 1) @(negedge clk);
        host_w(0, 32'h7FFFFFFF, 1'b0);
        host_b(1, 32'h7FFFFFFF, 1'b0);
        wait_idle();
        for (int i = 0; i < NI; i++) m_x[i] = $urandom();
        run_frame(1);

        // Reset during neuron 1 MAC: only neuron 0 may come out.
        for (int i = 0; i < NI; i++) m_x[i] = $urandom();
        send_frame(0, e);
        push_model(e, 1, 1'b0);
        while (cyc < e + PERIOD + 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy",  32'(bus.busy), 32'd0);
        check("midrst_ready", 32'(bus.data_in_ready), 32'd1);
        check("midrst_data",  bus.data_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        wait_idle();
        for (int i = 0; i < NI; i++) m_x[i] = $urandom();
        run_frame(0);

        // Wrap: each product is 0xFFFE0000, the sum wraps modulo 2^32.
        for (int k = 0; k < WD; k++) host_w(k, 32'h7FFF0000, 1'b1);
        for (int k = 0; k < NO; k++) host_b(k, $urandom(), 1'b1);
        for (int i = 0; i < NI; i++) m_x[i] = 32'h20000;
        run_frame(0);

        for (int f = 0; f < 4; f++) begin
            load_random_params();
            for (int i = 0; i < NI; i++) m_x[i] = $urandom();
            run_frame(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
